conv_scheduler: RTL
===================

# conv_scheduler

Periodic conversion scheduler that sits directly upstream of the ADC `control_unit`. It issues single-cycle `start_conversion` pulses at a programmable interval and tracks each SPI frame through `control_unit`'s `cs_n`. At the end of each frame it captures the `comparison_result` bit. It also debounces the captured results into a stable `alarm` output and flags frames that never start or never finish.

## Interface
Parameters:
- `PERIOD_W`, 16, width of the `period` input and of the period timer.
- `CONFIRM_N`, 3, number of consecutive equal samples needed to change `alarm` (≥1).
- `TIMEOUT_CYCLES`, 256, watchdog limit in clocks for each frame phase.

Ports:
- `clk`  in  1  clock; the only clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `enable`  in  1  run scheduling; low aborts to IDLE.
- `period`  in  PERIOD_W  trigger-to-trigger interval in clocks; values below 4 are treated as 4.
- `clear_err`  in  1  clears `timeout_err`.
- `cs_n`  in  1  chip select from `control_unit`; low means a frame is in progress.
- `comparison_result`  in  1  comparison result from `control_unit`; valid when `cs_n` rises.
- `start_conversion`  out  1  one-cycle trigger pulse to `control_unit`.
- `sample_valid`  out  1  one-cycle pulse; `sample_bit` is new.
- `sample_bit`  out  1  last captured `comparison_result`.
- `alarm`  out  1  debounced result.
- `timeout_err`  out  1  sticky watchdog flag.

## Operation
- FSM states: IDLE, TRIGGER, WAIT_START, WAIT_END, CAPTURE, WAIT_PERIOD.
- IDLE: when `enable`=1, go to TRIGGER.
- TRIGGER: `start_conversion`=1 for exactly this cycle; the period timer loads max(`period`,4)-1 and counts down to 0, then holds. Go to WAIT_START.
- WAIT_START: on `cs_n`=0, go to WAIT_END.
- WAIT_END: on `cs_n`=1, register `comparison_result` into `sample_bit`. Go to CAPTURE.
- CAPTURE: `sample_valid`=1 for this cycle; the debouncer updates. Go to WAIT_PERIOD.
- WAIT_PERIOD: when the timer is 0, go to TRIGGER. If a frame overruns the period, the next trigger follows CAPTURE by one cycle; triggers never overlap a frame.
- Debounce: a counter saturates at CONFIRM_N. It counts consecutive captured samples that differ from `alarm`; a sample equal to `alarm` resets it to 0. When the count reaches CONFIRM_N, `alarm` toggles and the counter clears.
- `enable`=0 in any state: next state is IDLE, the debounce counter clears, and `alarm`, `sample_bit` and `timeout_err` hold. A frame in progress is abandoned with no capture.
- `clear_err`=1 clears `timeout_err` next cycle. A simultaneous new timeout wins, and the flag stays 1.
- The `period` input is sampled only in TRIGGER. Changes mid-interval take effect on the next trigger.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, timers 0, and every output 0 (`start_conversion`, `sample_valid`, `sample_bit`, `alarm`, `timeout_err`).
- `enable` sampled 1 at edge k in IDLE: `start_conversion` is high in cycle k+1.
- `cs_n` sampled 1 at edge m in WAIT_END: `sample_valid`/`sample_bit` are valid in cycle m+1. `alarm` changes at the same edge as `sample_valid` rises.
- With period P≥4 and no overrun, rising edges of `start_conversion` are exactly P cycles apart.
- `cs_n` and `comparison_result` are same-domain signals; there is no synchronizer.

## Configuration
- `CONV_SCHED_TIMEOUT_EN` defined: a watchdog counter runs in WAIT_START and WAIT_END, restarting on each state entry. If it reaches TIMEOUT_CYCLES without the awaited `cs_n` edge:
  - `timeout_err` is set;
  - there is no capture and no `sample_valid`;
  - the FSM goes to WAIT_PERIOD.
- Not defined: no watchdog logic; `timeout_err` is tied to 0; the FSM waits indefinitely; `clear_err` is ignored.

## Structure
- Package `conv_sched_pkg` holds:
  - the FSM state enum;
  - `MIN_PERIOD`=4;
  - default values of `CONFIRM_N` and `TIMEOUT_CYCLES`.
- One sub-module, `result_debounce`, holds the CONFIRM_N counter and the `alarm` register. Its inputs are `sample_valid`, `sample_bit` and a clear.

## Test plan
- Reset then `enable`=1 at edge 10, `period`=20, and a model driving `cs_n` low 2 cycles after each trigger for 8 cycles: `start_conversion` rises at cycles 11, 31, 51; `sample_valid` occurs 1 cycle after each `cs_n` rise.
- `CONFIRM_N`=3, results 1,1,0,1,1,1: `alarm` stays 0 through the fourth sample and rises with the sixth `sample_valid`. Then results 0,0,0 make `alarm` fall on the third.
- `period`=10 with a 15-cycle frame: each trigger occurs 1 cycle after CAPTURE; there is never a trigger while `cs_n`=0.
- With `CONV_SCHED_TIMEOUT_EN` and `TIMEOUT_CYCLES`=256, `cs_n` held high after a trigger: `timeout_err`=1 256 cycles after WAIT_START entry, no `sample_valid`, and the next trigger occurs. `clear_err` then clears the flag.
- `enable`→0 while `cs_n`=0: IDLE next cycle, no `sample_valid`, `alarm` retained. `enable`→1 retriggers after 1 cycle.
- `period`=0 and `period`=2: trigger spacing is 4 cycles.

Source files
------------

// File: rtl/conv_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// conv_sched_pkg
//   Shared types and constants for the conversion scheduler slice:
//   FSM state encoding, the minimum trigger period and default parameter
//   values used by conv_scheduler and result_debounce.
// ---------------------------------------------------------------------------
package conv_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_TRIGGER     = 3'd1,
        S_WAIT_START  = 3'd2,
        S_WAIT_END    = 3'd3,
        S_CAPTURE     = 3'd4,
        S_WAIT_PERIOD = 3'd5
    } state_t;

    localparam int unsigned MIN_PERIOD             = 4;
    localparam int unsigned CONFIRM_N_DEFAULT      = 3;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 256;

endpackage

// File: rtl/conv_scheduler_result_debounce.sv
// ---------------------------------------------------------------------------
// result_debounce
//   Debounces captured comparison results into a stable alarm level. A run
//   of CONFIRM_N consecutive samples that differ from the current alarm
//   toggles it; any sample equal to the alarm restarts the run.
//
// Ports:
//   i_clk          clock
//   i_rst_n        synchronous active-low reset (alarm and counter to 0)
//   i_sample_valid a new sample is presented this cycle
//   i_sample_bit   the sample value
//   i_clear        clears the run counter; alarm holds
//   o_alarm        debounced level
// ---------------------------------------------------------------------------
module result_debounce
    import conv_sched_pkg::*;
#(
    parameter int unsigned CONFIRM_N = CONFIRM_N_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sample_valid,
    input  logic i_sample_bit,
    input  logic i_clear,
    output logic o_alarm
);

    localparam int unsigned      CNT_W    = (CONFIRM_N < 2) ? 1 : $clog2(CONFIRM_N + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONFIRM_N - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_alarm;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_alarm <= 1'b0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_sample_valid) begin
            if (i_sample_bit == r_alarm) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                // This differing sample completes the run.
                r_alarm <= ~r_alarm;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_alarm = r_alarm;

endmodule

// File: rtl/conv_scheduler.sv
// ---------------------------------------------------------------------------
// conv_scheduler
//   Issues periodic start_conversion pulses to the ADC control_unit, tracks
//   each SPI frame through cs_n, captures comparison_result at the end of the
//   frame and debounces the captured results into an alarm level.
//
// Configuration:
//   CONV_SCHED_TIMEOUT_EN  when defined, a watchdog bounds WAIT_START and
//                          WAIT_END to TIMEOUT_CYCLES clocks and sets the
//                          sticky o_timeout_err; otherwise o_timeout_err is 0
//                          and i_clear_err is ignored.
//
// Ports:
//   i_clk                clock
//   i_rst_n              synchronous active-low reset
//   i_enable             run scheduling; low aborts to IDLE
//   i_period             trigger interval in clocks (values < 4 act as 4)
//   i_clear_err          clears o_timeout_err
//   i_cs_n               control_unit chip select, low during a frame
//   i_comparison_result  result bit, valid when cs_n rises
//   o_start_conversion   one-cycle trigger pulse
//   o_sample_valid       one-cycle pulse, o_sample_bit is new
//   o_sample_bit         last captured result
//   o_alarm              debounced result
//   o_timeout_err        sticky watchdog flag
// ---------------------------------------------------------------------------
module conv_scheduler
    import conv_sched_pkg::*;
#(
    parameter int unsigned PERIOD_W       = 16,
    parameter int unsigned CONFIRM_N      = CONFIRM_N_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_enable,
    input  logic [PERIOD_W-1:0] i_period,
    input  logic                i_clear_err,
    input  logic                i_cs_n,
    input  logic                i_comparison_result,
    output logic                o_start_conversion,
    output logic                o_sample_valid,
    output logic                o_sample_bit,
    output logic                o_alarm,
    output logic                o_timeout_err
);

    localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);

    state_t              r_state;
    logic [PERIOD_W-1:0] r_timer;
    logic                r_start;
    logic                r_valid;
    logic                r_sample;

    logic [PERIOD_W-1:0] w_period_load;
    logic                w_timer_done;
    logic                w_capture;
    logic                w_timeout;

    assign w_period_load = ((i_period < MIN_P) ? MIN_P : i_period) - PERIOD_W'(1);
    // The timer reaches 0 on this edge (or already sits there after an
    // overrun), so the next cycle can be TRIGGER and spacing stays exactly P.
    assign w_timer_done  = (r_timer <= PERIOD_W'(1));
    assign w_capture     = i_enable && (r_state == S_WAIT_END) && i_cs_n;

`ifdef CONV_SCHED_TIMEOUT_EN
    localparam int unsigned     WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] r_wd;
    logic            r_timeout_err;
    logic            w_waiting;

    // Counting only while the awaited cs_n edge is absent restarts the
    // watchdog automatically on each WAIT_START / WAIT_END entry.
    assign w_waiting = ((r_state == S_WAIT_START) &&  i_cs_n) ||
                       ((r_state == S_WAIT_END)   && !i_cs_n);
    assign w_timeout = i_enable && w_waiting && (r_wd == WD_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wd          <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (i_enable && w_waiting) begin
                r_wd <= r_wd + WD_W'(1);
            end else begin
                r_wd <= '0;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end else if (i_clear_err) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

    assign o_timeout_err = r_timeout_err;
`else
    localparam int unsigned UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;
    logic w_unused_clear_err;

    assign w_unused_clear_err = i_clear_err;
    assign w_timeout          = 1'b0;
    assign o_timeout_err      = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_timer  <= '0;
            r_start  <= 1'b0;
            r_valid  <= 1'b0;
            r_sample <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_valid <= 1'b0;
            if (r_timer != '0) begin
                r_timer <= r_timer - PERIOD_W'(1);
            end

            if (!i_enable) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_TRIGGER;
                        r_start <= 1'b1;
                    end
                    S_TRIGGER: begin
                        r_timer <= w_period_load;
                        r_state <= S_WAIT_START;
                    end
                    S_WAIT_START: begin
                        if (!i_cs_n) begin
                            r_state <= S_WAIT_END;
                        end else if (w_timeout) begin
                            r_state <= S_WAIT_PERIOD;
                        end
                    end
                    S_WAIT_END: begin
                        if (i_cs_n) begin
                            r_sample <= i_comparison_result;
                            r_valid  <= 1'b1;
                            r_state  <= S_CAPTURE;
                        end else if (w_timeout) begin
                            r_state <= S_WAIT_PERIOD;
                        end
                    end
                    // On an overrun (or the minimum period) the next trigger
                    // must follow CAPTURE directly, so CAPTURE may skip
                    // WAIT_PERIOD when the interval has already elapsed.
                    S_CAPTURE, S_WAIT_PERIOD: begin
                        if (w_timer_done) begin
                            r_state <= S_TRIGGER;
                            r_start <= 1'b1;
                        end else begin
                            r_state <= S_WAIT_PERIOD;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    result_debounce #(
        .CONFIRM_N(CONFIRM_N)
    ) u_debounce (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_sample_valid(w_capture),
        .i_sample_bit  (i_comparison_result),
        .i_clear       (!i_enable),
        .o_alarm       (o_alarm)
    );

    assign o_start_conversion = r_start;
    assign o_sample_valid     = r_valid;
    assign o_sample_bit       = r_sample;

endmodule
